// File: rtl/axis_output_packer.sv
// -----------------------------------------------------------------------------
// axis_output_packer
//
// Compacts sparse-tkeep AXI-Stream beats into dense, low-aligned beats while
// preserving word order and packet boundaries. Sits downstream of the
// accelerator output adapter.
//
// The buffer holds up to 2*WORDS words. A full beat is emitted whenever at
// least WORDS words are buffered. A partial beat is emitted only as the final
// beat of a packet. When a packet ends, flush_q holds off new input until the
// packet's tail (possibly an empty beat) has been emitted.
//
// Ports
//   aclk           : clock, rising edge
//   aresetn        : synchronous active-low reset
//   s_axis_tready  : upstream ready (registered state only)
//   s_axis_tvalid  : upstream valid
//   s_axis_tdata   : WORDS words, word i at [i*WORD_WIDTH_ACC +: WORD_WIDTH_ACC]
//   s_axis_tkeep   : per-word valid mask (may be sparse)
//   s_axis_tlast   : input packet end
//   m_axis_tready  : downstream ready
//   m_axis_tvalid  : output valid (registered state only)
//   m_axis_tdata   : packed words, unused lanes driven to 0
//   m_axis_tkeep   : contiguous low-aligned keep
//   m_axis_tlast   : output packet end
// -----------------------------------------------------------------------------
module axis_output_packer #(
  parameter int WORD_WIDTH_ACC = 32,
  parameter int WORDS          = 4
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tvalid,
  input  logic [WORDS*WORD_WIDTH_ACC-1:0] s_axis_tdata,
  input  logic [WORDS-1:0]                s_axis_tkeep,
  input  logic                            s_axis_tlast,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tvalid,
  output logic [WORDS*WORD_WIDTH_ACC-1:0] m_axis_tdata,
  output logic [WORDS-1:0]                m_axis_tkeep,
  output logic                            m_axis_tlast
);

  localparam int DEPTH = 2 * WORDS;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] WORDS_C = CW'(WORDS);

  typedef logic [WORD_WIDTH_ACC-1:0] word_t;

  // Registered state
  word_t         word_q [DEPTH];
  word_t         word_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flush_q, flush_d;

  // Combinational helpers
  logic [CW-1:0] out_words;          // min(cnt, WORDS)
  logic          in_fire, out_fire;
  logic [CW-1:0] pre [WORDS+1];      // pre[i] = popcount(keep[i-1:0])
  logic [CW-1:0] in_words;           // popcount(keep)
  word_t         in_packed [WORDS];  // kept input words, compacted to index 0
  word_t         shifted [DEPTH];    // buffer after removing emitted words
  logic [CW-1:0] pop_words;          // words removed this cycle
  logic [CW-1:0] base;               // append position for incoming words

  // ---------------------------------------------------------------------------
  // Outputs: functions of registered state only (plus the reset gate), so
  // neither ready depends combinationally on the other side.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    out_words     = (cnt_q >= WORDS_C) ? WORDS_C : cnt_q;
    s_axis_tready = aresetn & ~flush_q & (cnt_q <= WORDS_C);
    m_axis_tvalid = aresetn & ((cnt_q >= WORDS_C) | flush_q);
    m_axis_tlast  = aresetn & flush_q & (cnt_q <= WORDS_C);
    m_axis_tkeep  = '0;
    m_axis_tdata  = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (aresetn && (CW'(i) < out_words)) begin
        m_axis_tkeep[i]                                  = 1'b1;
        m_axis_tdata[i*WORD_WIDTH_ACC +: WORD_WIDTH_ACC] = word_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state: compact input, drop emitted words, append survivors + input.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_fire   = s_axis_tvalid & s_axis_tready;
    out_fire  = m_axis_tvalid & m_axis_tready;
    pop_words = out_fire ? out_words : '0;

    // Prefix popcount gives each kept word its slot in the compacted vector.
    pre[0] = '0;
    for (int i = 0; i < WORDS; i++) begin
      pre[i+1] = pre[i] + CW'(s_axis_tkeep[i]);
    end
    in_words = pre[WORDS];

    for (int j = 0; j < WORDS; j++) begin
      in_packed[j] = '0;
      for (int i = 0; i < WORDS; i++) begin
        if (s_axis_tkeep[i] && (pre[i] == CW'(j))) begin
          in_packed[j] = s_axis_tdata[i*WORD_WIDTH_ACC +: WORD_WIDTH_ACC];
        end
      end
    end

    // Shift down by the number of words emitted (0..WORDS), zero-filling top.
    for (int j = 0; j < DEPTH; j++) begin
      shifted[j] = '0;
    end
    for (int k = 0; k <= WORDS; k++) begin
      if (pop_words == CW'(k)) begin
        for (int j = 0; j < DEPTH - k; j++) begin
          shifted[j] = word_q[j+k];
        end
      end
    end

    // Incoming words land directly after the words that remain. Input is only
    // accepted with cnt <= WORDS, so base + in_words never exceeds DEPTH.
    base = cnt_q - pop_words;
    for (int j = 0; j < DEPTH; j++) begin
      word_d[j] = shifted[j];
      for (int m = 0; m < WORDS; m++) begin
        if (in_fire && (CW'(m) < in_words) && ((base + CW'(m)) == CW'(j))) begin
          word_d[j] = in_packed[m];
        end
      end
    end

    cnt_d = base + (in_fire ? in_words : '0);

    // Set and clear can never coincide: input needs flush_q=0, while the
    // tlast beat needs flush_q=1.
    flush_d = flush_q;
    if (out_fire && m_axis_tlast) flush_d = 1'b0;
    if (in_fire && s_axis_tlast)  flush_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!aresetn) begin
      cnt_q   <= '0;
      flush_q <= 1'b0;
      // NOTE: the word buffer is deliberately reset so that no stale word from
      // an aborted packet can ever reach the output after reset.
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= word_d[i];
      end
    end
  end

endmodule

// File: tb/tb_axis_output_packer.sv
// -----------------------------------------------------------------------------
// tb_axis_output_packer
//
// Scoreboard bench for axis_output_packer (WORDS=4, 32-bit words). Kept input
// words and packet lengths are queued when the input handshake happens and
// are popped and compared when output beats are accepted.
// -----------------------------------------------------------------------------
module tb_axis_output_packer;

  localparam int W  = 4;
  localparam int WW = 32;
  localparam int DW = W * WW;

  logic          aclk;
  logic          aresetn;
  logic          s_axis_tready;
  logic          s_axis_tvalid;
  logic [DW-1:0] s_axis_tdata;
  logic [W-1:0]  s_axis_tkeep;
  logic          s_axis_tlast;
  logic          m_axis_tready;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic [W-1:0]  m_axis_tkeep;
  logic          m_axis_tlast;

  axis_output_packer #(.WORD_WIDTH_ACC(WW), .WORDS(W)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tready (s_axis_tready),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] data;
    logic [W-1:0]  keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [W-1:0]  keep;
    logic          last;
    int            cyc;
  } obeat_t;

  beat_t         src_q[$];
  logic [WW-1:0] exp_words[$];
  int            pkt_q[$];
  obeat_t        log_q[$];

  int            n_checks = 0;
  int            n_fail   = 0;
  int            emitted;
  int            in_pkt_words;
  int            cyc = 0;
  int            first_in_cyc;
  int            m_ready_pct;
  int            gap_pct;
  logic          stalled_prev;
  logic [DW-1:0] prev_data;
  logic [W-1:0]  prev_keep;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic [WW-1:0] d3, input logic [WW-1:0] d2,
                               input logic [WW-1:0] d1, input logic [WW-1:0] d0,
                               input logic [W-1:0] keep, input logic last);
    beat_t b;
    b.data = {d3, d2, d1, d0};
    b.keep = keep;
    b.last = last;
    return b;
  endfunction

  task automatic clear_model();
    src_q.delete();
    exp_words.delete();
    pkt_q.delete();
    log_q.delete();
    emitted      = 0;
    in_pkt_words = 0;
    stalled_prev = 1'b0;
    first_in_cyc = -1;
  endtask

  // Called on the falling edge: everything seen here is what the next rising
  // edge will act on. Output side is scored before input side, because an
  // output beat accepted at an edge reflects state from before that edge.
  task automatic monitor();
    logic [DW-1:0] exp_data;
    logic [W-1:0]  exp_keep;
    logic          exp_last;
    int            rem;
    int            exp_n;
    if (stalled_prev) begin
      check("hold_data", m_axis_tdata, prev_data);
      check("hold_keep", DW'(m_axis_tkeep), DW'(prev_keep));
    end
    stalled_prev = m_axis_tvalid && !m_axis_tready;
    prev_data    = m_axis_tdata;
    prev_keep    = m_axis_tkeep;

    if (m_axis_tvalid && m_axis_tready) begin
      if (pkt_q.size() > 0) begin
        rem      = pkt_q[0] - emitted;
        exp_n    = (rem > W) ? W : rem;
        exp_last = (rem <= W);
      end else begin
        exp_n    = W;
        exp_last = 1'b0;
      end
      exp_data = '0;
      exp_keep = '0;
      if (exp_words.size() < exp_n)
        check("scoreboard_words", DW'(exp_words.size()), DW'(exp_n));
      for (int i = 0; i < exp_n && exp_words.size() > 0; i++) begin
        exp_data[i*WW +: WW] = exp_words.pop_front();
        exp_keep[i]          = 1'b1;
      end
      check("out_tkeep", DW'(m_axis_tkeep), DW'(exp_keep));
      check("out_tlast", DW'(m_axis_tlast), DW'(exp_last));
      check("out_tdata", m_axis_tdata, exp_data);
      emitted += exp_n;
      if (exp_last) begin
        if (pkt_q.size() > 0) void'(pkt_q.pop_front());
        emitted = 0;
      end
      log_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, cyc});
    end

    if (s_axis_tvalid && s_axis_tready) begin
      for (int i = 0; i < W; i++) begin
        if (s_axis_tkeep[i]) begin
          exp_words.push_back(s_axis_tdata[i*WW +: WW]);
          in_pkt_words++;
        end
      end
      if (s_axis_tlast) begin
        pkt_q.push_back(in_pkt_words);
        in_pkt_words = 0;
      end
      if (first_in_cyc < 0) first_in_cyc = cyc;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
  endtask

  task automatic drive();
    m_axis_tready = ($urandom_range(0, 99) < m_ready_pct);
    if (src_q.size() > 0 && ($urandom_range(0, 99) >= gap_pct)) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = src_q[0].data;
      s_axis_tkeep  = src_q[0].keep;
      s_axis_tlast  = src_q[0].last;
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic step();
    drive();
    @(negedge aclk);
    monitor();
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic run_drain(input string tag, input int budget);
    int b = 0;
    while ((src_q.size() > 0 || pkt_q.size() > 0 || exp_words.size() > 0) && b < budget) begin
      step();
      b++;
    end
    check({tag, "_drained"}, DW'(src_q.size() + pkt_q.size() + exp_words.size()), DW'(0));
  endtask

  task automatic apply_reset(input int n);
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      if (i == 0) begin
        check("rst_s_tready", DW'(s_axis_tready), DW'(0));
        check("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
        check("rst_m_tkeep",  DW'(m_axis_tkeep),  DW'(0));
        check("rst_m_tlast",  DW'(m_axis_tlast),  DW'(0));
        check("rst_m_tdata",  m_axis_tdata,       DW'(0));
      end
      @(posedge aclk);
      #1;
      cyc++;
    end
    aresetn = 1'b1;
    clear_model();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] d [6];
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    clear_model();
    repeat (3) @(posedge aclk);
    #1;
    apply_reset(2);

    // Two full beats, second carries tlast: back-to-back output, 1-cycle latency.
    m_ready_pct = 100;
    gap_pct     = 0;
    clear_model();
    src_q.push_back(mk(32'hD, 32'hC, 32'hB, 32'hA, 4'b1111, 1'b0));
    src_q.push_back(mk(32'h8, 32'h7, 32'h6, 32'h5, 4'b1111, 1'b1));
    run_drain("full2", 50);
    check("full2_nbeats", DW'(log_q.size()), DW'(2));
    if (log_q.size() == 2) begin
      check("full2_b0_data", log_q[0].data, {32'hD, 32'hC, 32'hB, 32'hA});
      check("full2_b0_keep", DW'(log_q[0].keep), DW'(4'b1111));
      check("full2_b0_last", DW'(log_q[0].last), DW'(0));
      check("full2_b1_data", log_q[1].data, {32'h8, 32'h7, 32'h6, 32'h5});
      check("full2_b1_last", DW'(log_q[1].last), DW'(1));
      check("full2_back2back", DW'(log_q[1].cyc - log_q[0].cyc), DW'(1));
      check("full2_latency", DW'(log_q[0].cyc - first_in_cyc), DW'(1));
    end

    // Sparse keep compaction across beats, ending in a 1-word tail.
    clear_model();
    src_q.push_back(mk(32'hDEAD, 32'hB, 32'hDEAD, 32'hA, 4'b0101, 1'b0));
    src_q.push_back(mk(32'hBEEF, 32'hBEEF, 32'hD, 32'hC, 4'b0011, 1'b0));
    src_q.push_back(mk(32'hE, 32'hCAFE, 32'hCAFE, 32'hCAFE, 4'b1000, 1'b1));
    run_drain("sparse", 50);
    check("sparse_nbeats", DW'(log_q.size()), DW'(2));
    if (log_q.size() == 2) begin
      check("sparse_b0_data", log_q[0].data, {32'hD, 32'hC, 32'hB, 32'hA});
      check("sparse_b0_last", DW'(log_q[0].last), DW'(0));
      check("sparse_b1_data", log_q[1].data, {32'h0, 32'h0, 32'h0, 32'hE});
      check("sparse_b1_keep", DW'(log_q[1].keep), DW'(4'b0001));
      check("sparse_b1_last", DW'(log_q[1].last), DW'(1));
    end

    // Empty packet: a single keep=0 tlast beat yields exactly one empty beat.
    clear_model();
    src_q.push_back(mk(32'h11, 32'h22, 32'h33, 32'h44, 4'b0000, 1'b1));
    run_drain("empty", 50);
    repeat (5) step();
    check("empty_nbeats", DW'(log_q.size()), DW'(1));
    if (log_q.size() == 1) begin
      check("empty_keep", DW'(log_q[0].keep), DW'(0));
      check("empty_data", log_q[0].data, DW'(0));
      check("empty_last", DW'(log_q[0].last), DW'(1));
    end

    // Backpressure for 10 cycles while streaming full beats.
    clear_model();
    m_ready_pct = 0;
    for (int i = 0; i < 6; i++)
      src_q.push_back(mk(32'h100 + 4*i + 3, 32'h100 + 4*i + 2, 32'h100 + 4*i + 1,
                         32'h100 + 4*i, 4'b1111, i == 5));
    repeat (10) step();
    check("bp_s_tready_low", DW'(s_axis_tready), DW'(0));
    check("bp_m_tvalid_high", DW'(m_axis_tvalid), DW'(1));
    check("bp_accepted", DW'(src_q.size()), DW'(4));
    m_ready_pct = 100;
    run_drain("bp", 100);
    check("bp_nbeats", DW'(log_q.size()), DW'(6));

    // Reset with 6 words buffered; the following packet must be intact.
    clear_model();
    m_ready_pct = 0;
    src_q.push_back(mk(32'hA3, 32'hA2, 32'hA1, 32'hA0, 4'b1111, 1'b0));
    src_q.push_back(mk(32'hA7, 32'hA6, 32'hA5, 32'hA4, 4'b0011, 1'b0));
    for (int b = 0; b < 20 && src_q.size() > 0; b++) step();
    check("rst6_loaded", DW'(src_q.size()), DW'(0));
    apply_reset(1);
    @(negedge aclk);
    check("rst6_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    check("rst6_s_tready", DW'(s_axis_tready), DW'(1));
    @(posedge aclk);
    #1;
    cyc++;
    m_ready_pct = 100;
    for (int i = 0; i < 6; i++) d[i] = 32'hF0 + i;
    src_q.push_back(mk(d[3], d[2], d[1], d[0], 4'b1111, 1'b0));
    src_q.push_back(mk(32'h5A5A, 32'h5A5A, d[5], d[4], 4'b0011, 1'b1));
    run_drain("rst6", 50);
    check("rst6_nbeats", DW'(log_q.size()), DW'(2));
    if (log_q.size() == 2) begin
      check("rst6_b0_data", log_q[0].data, {d[3], d[2], d[1], d[0]});
      check("rst6_b1_data", log_q[1].data, {32'h0, 32'h0, d[5], d[4]});
      check("rst6_b1_keep", DW'(log_q[1].keep), DW'(4'b0011));
      check("rst6_b1_last", DW'(log_q[1].last), DW'(1));
    end

    // Random keep, tlast, valid gaps and downstream ready.
    clear_model();
    m_ready_pct = 70;
    gap_pct     = 20;
    for (int i = 0; i < 10000; i++)
      src_q.push_back(mk($urandom(), $urandom(), $urandom(), $urandom(),
                         4'($urandom_range(0, 15)),
                         (i == 9999) || ($urandom_range(0, 7) == 0)));
    run_drain("rand", 80000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_output_packer.md
AXIS_OUTPUT_PACKER -- requirements
Module: axis_output_packer

Interface
REQ-001 SHALL have parameter WORD_WIDTH_ACC, default 32: width of one accumulator word in bits.
REQ-002 SHALL have parameter WORDS, default 4: words per beat, equal to M_OUTPUT_WIDTH_LF/WORD_WIDTH_ACC.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port aresetn, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port s_axis_tready, output, 1 bit: upstream ready.
REQ-006 SHALL have port s_axis_tvalid, input, 1 bit: upstream valid.
REQ-007 SHALL have port s_axis_tdata, input, WORDS*WORD_WIDTH_ACC bits: input words; word i occupies bits [i*WORD_WIDTH_ACC +: WORD_WIDTH_ACC].
REQ-008 SHALL have port s_axis_tkeep, input, WORDS bits: one bit per word; keep[i]=1 marks word i valid.
REQ-009 SHALL have port s_axis_tlast, input, 1 bit: input packet end.
REQ-010 SHALL have port m_axis_tready, input, 1 bit: downstream ready.
REQ-011 SHALL have port m_axis_tvalid, output, 1 bit: output valid.
REQ-012 SHALL have port m_axis_tdata, output, WORDS*WORD_WIDTH_ACC bits: packed output words.
REQ-013 SHALL have port m_axis_tkeep, output, WORDS bits: contiguous low-aligned keep.
REQ-014 SHALL have port m_axis_tlast, output, 1 bit: output packet end.

Function
REQ-015 SHALL sit downstream of the accelerator output adapter and compact sparse-tkeep beats into dense beats, preserving word order and packet boundaries.
REQ-016 SHALL hold a word buffer of capacity 2*WORDS, a count register cnt (0..2*WORDS) and a flush_pending flag.
REQ-017 On an input handshake, SHALL append the input words with keep=1, in ascending index order, after the words still buffered.
REQ-018 SHALL drive s_axis_tready = aresetn & ~flush_pending & (cnt <= WORDS), derived from registered state only and independent of m_axis_tready.
REQ-019 SHALL drive m_axis_tvalid = (cnt >= WORDS) | flush_pending, derived from registered state only.
REQ-020 SHALL place the lowest min(cnt, WORDS) buffered words in the output lanes starting at lane 0.
REQ-021 SHALL set m_axis_tkeep to (1<<min(cnt, WORDS))-1.
REQ-022 SHALL drive unused output lanes to 0.
REQ-023 SHALL drive m_axis_tlast = flush_pending & (cnt <= WORDS).
REQ-024 When cnt < WORDS and flush_pending=0, SHALL hold m_axis_tvalid low; a partial beat is never emitted except as the last beat of a packet.
REQ-025 On an output handshake, SHALL remove the emitted words and shift the remaining words down.
REQ-026 When input and output handshakes occur in the same cycle, SHALL update cnt_next = cnt - out_words + popcount(keep), with incoming words appended after the words that remain.
REQ-027 An input handshake with s_axis_tlast=1 SHALL set flush_pending.
REQ-028 SHALL clear flush_pending on the output handshake that carries m_axis_tlast=1.
REQ-029 If flush_pending=1 and cnt > WORDS, SHALL first emit a full beat with tlast=0, then the remainder with tlast=1.
REQ-030 If flush_pending=1 and cnt == WORDS, SHALL emit a single full beat with tlast=1.
REQ-031 If flush_pending=1 and cnt == 0 (packet ended in all-zero-keep beats), SHALL emit one beat with tkeep=0, tdata=0, tlast=1.
REQ-032 An input beat with tkeep=0 and tlast=0 SHALL be accepted and SHALL not change cnt.
REQ-033 Minimum latency from an input handshake to the first appearance of its words on the output SHALL be 1 cycle.
REQ-034 The block SHALL not add bubbles in steady state with all-ones keep and m_axis_tready=1 (one beat per cycle).
REQ-035 While m_axis_tvalid=1 and m_axis_tready=0, all m_axis outputs SHALL be held stable.

Reset
REQ-036 While aresetn=0 at a clock edge, SHALL set cnt=0 and flush_pending=0, and clear the buffer to 0.
REQ-037 While aresetn=0, SHALL hold s_axis_tready=0, m_axis_tvalid=0, m_axis_tkeep=0, m_axis_tlast=0 and m_axis_tdata=0.
REQ-038 Reset asserted mid-packet SHALL discard all buffered words.
REQ-039 After reset releases, the first output SHALL come from post-reset input only.

Verification (WORDS=4)
REQ-040 Scenario: in {A,B,C,D} keep=1111, then {E,F,G,H} keep=1111 tlast, m_ready=1 -> out {A,B,C,D} keep=1111 tlast=0, then {E,F,G,H} keep=1111 tlast=1, consecutive cycles.
REQ-041 Scenario: in keep=0101 {x,B,x,A}, then keep=0011 {y,y,D,C}, then keep=1000 {E,..} tlast -> out {A,B,C,D} keep=1111 tlast=0, then {E,0,0,0} keep=0001 tlast=1.
REQ-042 Scenario: single beat keep=0000 tlast=1 -> exactly one out beat keep=0000 tdata=0 tlast=1.
REQ-043 Scenario: m_ready=0 for 10 cycles while streaming full beats -> s_ready drops once cnt=8; outputs stable; no word lost or duplicated after m_ready=1.
REQ-044 Scenario: random keep and tlast, random m_ready, 10k beats -> output word sequence equals the scoreboard model; every non-last beat has keep=1111.
REQ-045 Scenario: aresetn=0 for 1 cycle with 6 words buffered -> next cycle m_valid=0, cnt=0; the subsequent packet is emitted intact.
